// File: rtl/serial_min_distance_finder_if.sv
// Handshake and result bus for the serial minimum-distance finder.
interface serial_min_distance_finder_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 4
);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dist;
  logic             in_last;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] min_dist;
  logic [IDX_W-1:0] min_idx;
  logic [IDX_W-1:0] count;

  modport master (
    output start, in_valid, in_dist, in_last,
    input  in_ready, busy, done, min_dist, min_idx, count
  );

  modport slave (
    input  start, in_valid, in_dist, in_last,
    output in_ready, busy, done, min_dist, min_idx, count
  );
endinterface

// File: rtl/serial_min_distance_finder.sv
// Streams unsigned distances and tracks the minimum and its index, comparing
// each candidate against the running minimum 2 bits per cycle, MSB pair first.
module serial_min_distance_finder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  serial_min_distance_finder_if.slave   bus
);
  localparam int NPAIR = WIDTH / 2;
  localparam int PW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;

  typedef enum logic [2:0] {IDLE, ACCEPT, COMPARE, UPDATE, DONE_HOLD} state_t;

  state_t           state_q;
  logic             in_ready_q, busy_q, done_q;
  logic [WIDTH-1:0] min_dist_q, cand_q;
  logic [IDX_W-1:0] min_idx_q, cand_idx_q, count_q;
  logic             first_q, last_q, eq_q, lt_q;
  logic [PW-1:0]    pair_q;

  // One 2-bit slice of the eq/lt cascade, selected by the pair pointer.
  logic [1:0] a_pair, b_pair;
  logic       eq_d, lt_d;
  always_comb begin
    a_pair = cand_q[2*int'(pair_q) +: 2];
    b_pair = min_dist_q[2*int'(pair_q) +: 2];
    lt_d   = lt_q | (eq_q & (a_pair < b_pair));
    eq_d   = eq_q & (a_pair == b_pair);
  end

  logic xfer;
  assign xfer = bus.in_valid & in_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      min_dist_q <= '0;
      min_idx_q  <= '0;
      count_q    <= '0;
      cand_q     <= '0;
      cand_idx_q <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      eq_q       <= 1'b1;
      lt_q       <= 1'b0;
      pair_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE_HOLD: begin
          if (bus.start) begin
            state_q    <= ACCEPT;
            count_q    <= '0;
            first_q    <= 1'b1;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
          end
        end
        ACCEPT: begin
          if (xfer) begin
            if (first_q) begin
              min_dist_q <= bus.in_dist;
              min_idx_q  <= '0;
              count_q    <= IDX_W'(1);
              first_q    <= 1'b0;
              if (bus.in_last) begin
                state_q    <= DONE_HOLD;
                done_q     <= 1'b1;
                busy_q     <= 1'b0;
                in_ready_q <= 1'b0;
              end
            end else begin
              cand_q     <= bus.in_dist;
              cand_idx_q <= count_q;
              count_q    <= count_q + IDX_W'(1);
              last_q     <= bus.in_last;
              eq_q       <= 1'b1;
              lt_q       <= 1'b0;
              pair_q     <= PW'(NPAIR - 1);
              in_ready_q <= 1'b0;
              state_q    <= COMPARE;
            end
          end
        end
        COMPARE: begin
          // Fixed latency: every pair is visited even once the outcome is known.
          eq_q   <= eq_d;
          lt_q   <= lt_d;
          pair_q <= pair_q - PW'(1);
          if (pair_q == '0) state_q <= UPDATE;
        end
        UPDATE: begin
          if (lt_q) begin
            min_dist_q <= cand_q;
            min_idx_q  <= cand_idx_q;
          end
          if (last_q) begin
            state_q <= DONE_HOLD;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q    <= ACCEPT;
            in_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.min_dist = min_dist_q;
  assign bus.min_idx  = min_idx_q;
  assign bus.count    = count_q;
endmodule
